lab_ctrl_iface: RTL

LAB_CTRL_IFACE -- requirements
Module: lab_ctrl_iface

---
 rtl/lab_ctrl_iface_pkg.sv | 29 ++
 rtl/lab_ctrl_iface_if.sv | 32 +++
 rtl/key_debounce.sv | 86 ++++++++
 rtl/lab_ctrl_iface.sv | 109 ++++++++++
 4 files changed

// File: rtl/lab_ctrl_iface_pkg.sv
// Shared definitions for the lab control front end: debounce FSM states,
// ctrl_q field positions and the byte-lane index width helper.
package lab_ctrl_iface_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CNT = 2'd1,
        HELD      = 2'd2,
        REL_CNT   = 2'd3
    } deb_state_e;

    localparam int CTRL_W          = 9;
    localparam int CTRL_WRITE_BIT  = 0;
    localparam int CTRL_REGNUM_LSB = 1;
    localparam int CTRL_SHIFT_LSB  = 1;
    localparam int CTRL_ASEL_BIT   = 3;
    localparam int CTRL_VSEL_BIT   = 4;
    localparam int CTRL_LOADA_BIT  = 5;
    localparam int CTRL_ALUOP_LSB  = 5;
    localparam int CTRL_LOADB_BIT  = 6;
    localparam int CTRL_LOADC_BIT  = 7;
    localparam int CTRL_LOADS_BIT  = 8;

    // A single-lane word still needs a 1-bit lane index.
    function automatic int lane_width(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/lab_ctrl_iface_if.sv
// Bundle of the datapath-facing outputs; master drives them, slave consumes them.
interface lab_ctrl_iface_if #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 1
);
    logic [DATA_W-1:0] datapath_in;
    logic [2:0]        readnum;
    logic [2:0]        writenum;
    logic [1:0]        shift;
    logic [1:0]        ALUop;
    logic              write;
    logic              vsel;
    logic              loada;
    logic              loadb;
    logic              asel;
    logic              bsel;
    logic              loadc;
    logic              loads;
    logic              dp_en;
    logic [LANE_W-1:0] lane;
    logic [8:0]        LEDR;

    modport master (
        output datapath_in, readnum, writenum, shift, ALUop, write, vsel,
               loada, loadb, asel, bsel, loadc, loads, dp_en, lane, LEDR
    );

    modport slave (
        input  datapath_in, readnum, writenum, shift, ALUop, write, vsel,
               loada, loadb, asel, bsel, loadc, loads, dp_en, lane, LEDR
    );
endinterface

// File: rtl/key_debounce.sv
// Pushbutton synchronizer and debounce FSM; press_pulse is high for the single
// cycle in which a press has been stable for DEBOUNCE_CYC samples.
module key_debounce
    import lab_ctrl_iface_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse
);
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic       key_meta_q, key_sync_q;
    logic       pressed;
    deb_state_e state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign pressed = ~key_sync_q;

    // The sample that leaves IDLE/HELD already counts as the first stable one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_CNT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_CNT: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    press_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = REL_CNT;
                    cnt_d   = CNT_ONE;
                end
            end
            REL_CNT: begin
                if (pressed) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: rtl/lab_ctrl_iface.sv
// Switch/pushbutton front end: assembles a data word byte by byte in data mode
// and loads a 9-bit control word (with a dp_en strobe) in control mode.
module lab_ctrl_iface
    import lab_ctrl_iface_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_n,
    input  logic [9:0]                    SW,
    output logic [DATA_W-1:0]             datapath_in,
    output logic [2:0]                    readnum,
    output logic [2:0]                    writenum,
    output logic [1:0]                    shift,
    output logic [1:0]                    ALUop,
    output logic                          write,
    output logic                          vsel,
    output logic                          loada,
    output logic                          loadb,
    output logic                          asel,
    output logic                          bsel,
    output logic                          loadc,
    output logic                          loads,
    output logic                          dp_en,
    output logic [lane_width(DATA_W)-1:0] lane,
    output logic [8:0]                    LEDR
);
    localparam int               LANE_W    = lane_width(DATA_W);
    localparam int               NUM_LANES = DATA_W / 8;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);

    logic [9:0]        sw_meta_q, sw_sync_q;
    logic              mode, mode_prev_q, mode_rise;
    logic              step, data_step;
    logic [LANE_W-1:0] wr_lane, lane_d, lane_q;
    logic [DATA_W-1:0] datapath_d, datapath_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic              dp_en_d, dp_en_q;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_debounce (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .press_pulse (step)
    );

    assign mode      = sw_sync_q[9];
    assign mode_rise = mode & ~mode_prev_q;
    // A step in the same cycle as entering data mode must already use lane 0.
    assign wr_lane   = mode_rise ? '0 : lane_q;
    assign data_step = step & mode;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign datapath_d[8*gi +: 8] = (data_step && wr_lane == LANE_W'(gi))
                                       ? sw_sync_q[7:0] : datapath_q[8*gi +: 8];
    end

    always_comb begin
        lane_d  = mode_rise ? '0 : lane_q;
        ctrl_d  = ctrl_q;
        dp_en_d = 1'b0;
        if (data_step) begin
            lane_d = (wr_lane == LANE_LAST) ? '0 : wr_lane + LANE_W'(1);
        end else if (step) begin
            ctrl_d  = sw_sync_q[CTRL_W-1:0];
            dp_en_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            mode_prev_q <= 1'b0;
            lane_q      <= '0;
            datapath_q  <= '0;
            ctrl_q      <= '0;
            dp_en_q     <= 1'b0;
        end else begin
            sw_meta_q   <= SW;
            sw_sync_q   <= sw_meta_q;
            mode_prev_q <= mode;
            lane_q      <= lane_d;
            datapath_q  <= datapath_d;
            ctrl_q      <= ctrl_d;
            dp_en_q     <= dp_en_d;
        end
    end

    assign datapath_in = datapath_q;
    assign lane        = lane_q;
    assign dp_en       = dp_en_q;
    assign readnum     = ctrl_q[CTRL_REGNUM_LSB +: 3];
    assign writenum    = ctrl_q[CTRL_REGNUM_LSB +: 3];
    assign shift       = ctrl_q[CTRL_SHIFT_LSB +: 2];
    assign ALUop       = ctrl_q[CTRL_ALUOP_LSB +: 2];
    assign write       = ctrl_q[CTRL_WRITE_BIT];
    assign vsel        = ctrl_q[CTRL_VSEL_BIT];
    assign bsel        = ctrl_q[CTRL_VSEL_BIT];
    assign asel        = ctrl_q[CTRL_ASEL_BIT];
    assign loada       = ctrl_q[CTRL_LOADA_BIT];
    assign loadb       = ctrl_q[CTRL_LOADB_BIT];
    assign loadc       = ctrl_q[CTRL_LOADC_BIT];
    assign loads       = ctrl_q[CTRL_LOADS_BIT];
    assign LEDR        = mode ? ctrl_q : {1'b0, datapath_q[7:0]};

endmodule
